// File: rtl/mau_nch_pkg.sv
// Shared types and defaults for the multi-channel memory abstraction unit.
// Holds the FSM encoding, access-mode encoding and the channel select helpers.
package mau_nch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FAULT = 2'd2
    } mau_state_t;

    typedef enum logic {
        MODE_MEM = 1'b0,
        MODE_PER = 1'b1
    } mau_mode_t;

    localparam logic [15:0] DEF_PER_BASE = 16'hFE00;
    localparam logic [15:0] DEF_ERR_DATA = 16'hDEAD;

    // Channel index width covers the largest supported channel count (8).
    localparam int CHW = 3;

    typedef struct packed {
        mau_mode_t        mode;
        logic [CHW-1:0]   chan;
    } mau_sel_t;

    function automatic logic [7:0] chan_onehot(input logic [CHW-1:0] c);
        chan_onehot = 8'd1 << c;
    endfunction

endpackage

// File: rtl/mau_decode.sv
// Address decoder: splits MAR into memory/peripheral space, channel and
// per-channel word address, and flags peripheral addresses beyond NCH channels.
module mau_decode
    import mau_nch_pkg::*;
#(
    parameter int              AW       = 16,
    parameter int              PAW      = 6,
    parameter int              NCH      = 4,
    parameter logic [AW-1:0]   PER_BASE = DEF_PER_BASE
) (
    input  logic [AW-1:0]  mar,
    output mau_mode_t      mode,
    output logic [CHW-1:0] chan,
    output logic [PAW-1:0] per_addr,
    output logic           unmapped
);

    logic [AW-1:0] off_s;
    logic [AW-1:0] chan_full_s;

    // Byte offset into peripheral space becomes a word offset; upper bits pick the channel.
    always_comb begin
        off_s       = (mar - PER_BASE) >> 1;
        chan_full_s = off_s >> PAW;
        mode        = (mar < PER_BASE) ? MODE_MEM : MODE_PER;
        per_addr    = off_s[PAW-1:0];
        chan        = chan_full_s[CHW-1:0];
        unmapped    = (mode == MODE_PER) && (chan_full_s >= AW'(NCH));
    end

endmodule

// File: rtl/tri_buf.sv
// Tristate buffer cell: drives d onto y while en is high, otherwise releases y.
module tri_buf #(
    parameter int W = 16
) (
    input  logic         en,
    input  logic [W-1:0] d,
    output wire  [W-1:0] y
);

    assign y = en ? d : {W{1'bz}};

endmodule

// File: rtl/mau_nch.sv
// Multi-channel memory abstraction unit: LC-3 MAR/MDR front end routing each
// access to memory or one of NCH peripherals, with timeout and sticky fault capture.
module mau_nch
    import mau_nch_pkg::*;
#(
    parameter int              DW       = 16,
    parameter int              AW       = 16,
    parameter logic [AW-1:0]   PER_BASE = DEF_PER_BASE,
    parameter int              NCH      = 4,
    parameter int              PAW      = 6,
    parameter int              TIMEOUT  = 255,
    parameter logic [DW-1:0]   ERR_DATA = DEF_ERR_DATA
) (
    input  logic              clk,
    input  logic              arst_n,
    inout  wire  [DW-1:0]     bus,
    input  logic              cpu_ld_mar,
    input  logic              cpu_ld_mdr,
    input  logic              cpu_gate_mdr,
    input  logic              cpu_mio_en,
    input  logic              cpu_rw,
    output logic              cpu_rdy,
    output logic              mem_init_txn,
    output logic              mem_wtxn,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    input  logic              mem_rdy,
    output logic [NCH-1:0]    per_init_txn,
    output logic              per_wtxn,
    output logic [PAW-1:0]    per_addr,
    output logic [DW-1:0]     per_wdata,
    input  logic [NCH*DW-1:0] per_rdata,
    input  logic [NCH-1:0]    per_rdy,
    output logic              err,
    output logic [AW-1:0]     err_addr,
    input  logic              err_clr
);

    mau_state_t     state_r;
    logic [AW-1:0]  mar_r;
    logic [DW-1:0]  mdr_r;
    logic           mio_q_r;
    logic [15:0]    cnt_r;
    mau_sel_t       sel_r;
    logic           err_r;
    logic [AW-1:0]  err_addr_r;

    mau_mode_t      dec_mode_s;
    logic [CHW-1:0] dec_chan_s;
    logic [PAW-1:0] dec_paddr_s;
    logic           dec_unmapped_s;

    mau_sel_t       rd_sel_s;
    logic [7:0]     per_rdy_ext_s;
    logic [DW-1:0]  sel_rdata_s;
    logic           sel_rdy_s;
    logic           tmo_s;
    logic           start_s;
    logic           fault_s;
    logic [DW-1:0]  mdr_mux_s;

    mau_decode #(
        .AW       (AW),
        .PAW      (PAW),
        .NCH      (NCH),
        .PER_BASE (PER_BASE)
    ) u_decode (
        .mar      (mar_r),
        .mode     (dec_mode_s),
        .chan     (dec_chan_s),
        .per_addr (dec_paddr_s),
        .unmapped (dec_unmapped_s)
    );

    tri_buf #(
        .W (DW)
    ) u_bus_drv (
        .en (cpu_gate_mdr),
        .d  (mdr_r),
        .y  (bus)
    );

    // Slave select: latched target while BUSY, live decode otherwise.
    always_comb begin
        per_rdy_ext_s = 8'(per_rdy);
        if (state_r == ST_BUSY) begin
            rd_sel_s = sel_r;
        end else begin
            rd_sel_s = {dec_mode_s, dec_chan_s};
        end
        if (rd_sel_s.mode == MODE_PER) begin
            sel_rdata_s = DW'(per_rdata >> (32'(rd_sel_s.chan) * DW));
            sel_rdy_s   = per_rdy_ext_s[rd_sel_s.chan];
        end else begin
            sel_rdata_s = mem_rdata;
            sel_rdy_s   = mem_rdy;
        end
    end

    // Start detection, transaction strobes, completion and MDR input mux.
    always_comb begin
        tmo_s        = (cnt_r == 16'(TIMEOUT - 1));
        start_s      = cpu_mio_en & ~mio_q_r & (state_r == ST_IDLE);
        mem_init_txn = start_s & ~dec_unmapped_s & (dec_mode_s == MODE_MEM);
        if (start_s && !dec_unmapped_s && (dec_mode_s == MODE_PER)) begin
            per_init_txn = NCH'(chan_onehot(dec_chan_s));
        end else begin
            per_init_txn = '0;
        end
        // A ready response in the last allowed cycle still counts as success.
        fault_s = (state_r == ST_FAULT) ||
                  ((state_r == ST_BUSY) && !sel_rdy_s && tmo_s);
        case (state_r)
            ST_IDLE:  cpu_rdy = ~start_s;
            ST_BUSY:  cpu_rdy = sel_rdy_s | tmo_s;
            ST_FAULT: cpu_rdy = 1'b1;
            default:  cpu_rdy = 1'b1;
        endcase
        if (!cpu_mio_en) begin
            mdr_mux_s = bus;
        end else if (fault_s) begin
            mdr_mux_s = ERR_DATA;
        end else begin
            mdr_mux_s = sel_rdata_s;
        end
    end

    // Access FSM with timeout counter and latched slave select.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
            sel_r   <= '0;
            mio_q_r <= 1'b0;
        end else begin
            mio_q_r <= cpu_mio_en;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        if (dec_unmapped_s) begin
                            state_r <= ST_FAULT;
                        end else begin
                            state_r <= ST_BUSY;
                            sel_r   <= {dec_mode_s, dec_chan_s};
                            cnt_r   <= 16'd0;
                        end
                    end
                end
                ST_BUSY: begin
                    if (sel_rdy_s || tmo_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_FAULT: state_r <= ST_IDLE;
                default:  state_r <= ST_IDLE;
            endcase
        end
    end

    // MAR/MDR datapath registers.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            mar_r <= '0;
            mdr_r <= '0;
        end else begin
            if (cpu_ld_mar) begin
                mar_r <= bus;
            end
            if (cpu_ld_mdr) begin
                mdr_r <= mdr_mux_s;
            end
        end
    end

    // Sticky fault capture; a fault in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            err_r      <= 1'b0;
            err_addr_r <= '0;
        end else if (fault_s) begin
            err_r <= 1'b1;
            if (!err_r) begin
                err_addr_r <= mar_r;
            end
        end else if (err_clr) begin
            err_r <= 1'b0;
        end
    end

    assign mem_wtxn  = cpu_rw;
    assign per_wtxn  = cpu_rw;
    assign mem_addr  = mar_r;
    assign mem_wdata = mdr_r;
    assign per_wdata = mdr_r;
    assign per_addr  = dec_paddr_s;
    assign err       = err_r;
    assign err_addr  = err_addr_r;

endmodule
